// File: rtl/banco_registros_if.sv
// -----------------------------------------------------------------------------
// banco_registros_if
// Port bundle of the ID-stage integer register file.
//   read_reg1  : index of read port 1 (Rn)
//   read_reg2  : index of read port 2 (Rm / Rt for stores)
//   write_reg  : destination index coming back from WB
//   write_data : value from the WB result mux
//   reg_write  : write enable from WB control
//   read_data1 : contents of read_reg1, feeds ALU operand A
//   read_data2 : contents of read_reg2, feeds the operand-B register/immediate mux
// Modports: master = pipeline side (drives indices and write bus),
//           slave  = register file.
// -----------------------------------------------------------------------------
interface banco_registros_if #(
    parameter int WIDTH = 64,
    parameter int NREG  = 32
);
    localparam int IDX_W = $clog2(NREG);

    logic [IDX_W-1:0] read_reg1;
    logic [IDX_W-1:0] read_reg2;
    logic [IDX_W-1:0] write_reg;
    logic [WIDTH-1:0] write_data;
    logic             reg_write;
    logic [WIDTH-1:0] read_data1;
    logic [WIDTH-1:0] read_data2;

    modport master (
        output read_reg1,
        output read_reg2,
        output write_reg,
        output write_data,
        output reg_write,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  read_reg1,
        input  read_reg2,
        input  write_reg,
        input  write_data,
        input  reg_write,
        output read_data1,
        output read_data2
    );
endinterface

// File: rtl/banco_registros.sv
// -----------------------------------------------------------------------------
// banco_registros
// 64-bit x 32-entry integer register file for the ID stage.
// Two combinational read ports, one synchronous write port from WB.
// Index ZERO_IDX (31) is XZR: always reads 0, writes to it are discarded.
// A write presented in the same cycle as a read of the same index is
// forwarded to the read port, so WB and ID can share a cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears every register (wins over a write)
//   bus   : banco_registros_if.slave (read indices, write bus, read data)
// -----------------------------------------------------------------------------
module banco_registros #(
    parameter int WIDTH    = 64,
    parameter int NREG     = 32,
    parameter int ZERO_IDX = 31
) (
    input  logic                clk,
    input  logic                reset,
    banco_registros_if.slave    bus
);
    localparam int               IDX_W     = $clog2(NREG);
    localparam logic [IDX_W-1:0] ZERO_ADDR = IDX_W'(ZERO_IDX);

    logic [WIDTH-1:0] r_mem [NREG];

    logic w_write_en;
    logic w_bypass_en;

    // The write bus is only meaningful outside reset; reset also hides the
    // in-flight write from the read ports.
    assign w_bypass_en = bus.reg_write && !reset;
    assign w_write_en  = w_bypass_en && (bus.write_reg != ZERO_ADDR);

    // NOTE: the storage array is cleared on reset because the pipeline relies
    // on every architectural register reading 0 afterwards; this costs a reset
    // mux per flop, which a plain RAM macro could not provide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                // NOTE: non-blocking assignment for all clocked state, so every
                // flop samples pre-edge values regardless of statement order.
                r_mem[i] <= '0;
            end
        end else if (w_write_en) begin
            r_mem[bus.write_reg] <= bus.write_data;
        end
    end

    // Read priority: XZR, then same-cycle bypass, then stored value.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [IDX_W-1:0] idx,
        input logic             bypass_en,
        input logic [IDX_W-1:0] wr_idx,
        input logic [WIDTH-1:0] wr_data,
        input logic [WIDTH-1:0] stored
    );
        logic [WIDTH-1:0] value;
        if (idx == ZERO_ADDR) begin
            value = '0;
        end else if (bypass_en && (wr_idx == idx)) begin
            value = wr_data;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    always_comb begin
        // NOTE: defaults first in every combinational block so no path leaves
        // an output unassigned and infers a latch.
        bus.read_data1 = '0;
        bus.read_data2 = '0;
        bus.read_data1 = read_port(bus.read_reg1, w_bypass_en, bus.write_reg,
                                   bus.write_data, r_mem[bus.read_reg1]);
        bus.read_data2 = read_port(bus.read_reg2, w_bypass_en, bus.write_reg,
                                   bus.write_data, r_mem[bus.read_reg2]);
    end
endmodule
